// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the program-counter stage.
//   XLEN                 - architectural register / PC width.
//   PC_ALIGN_MASK        - low PC bits that must be zero for a legal fetch target.
//   DEFAULT_RESET_VECTOR - PC loaded on reset unless overridden by the top parameter.
//   pc_state_t           - FSM state type (BOOT, RUN, TRAP, HALT).
//   ST_*                 - the same state encodings as plain 2-bit constants.
package pc_pkg;

    localparam int XLEN = 32;
    localparam logic [1:0] PC_ALIGN_MASK = 2'b11;
    localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        TRAP = 2'd2,
        HALT = 2'd3
    } pc_state_t;

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_TRAP = 2'd2;
    localparam logic [1:0] ST_HALT = 2'd3;

endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: bundle between the core control logic and the PC stage.
//   Core -> PC stage : pc_plus4_i, branch_taken_i, branch_target_i, jump_i,
//                      jump_target_i, stall_i, halt_i
//   PC stage -> core : pc_o, imem_req_o, trap_o, trap_pc_o, halted_o,
//                      instret_o, state_o (FSM state, debug visibility)
// Fetch handshake: imem_req_o is a valid with no ready; whenever it is high,
// pc_o is a fetch address the instruction memory must accept that cycle.
// The slave modport is the PC stage; the master modport is the surrounding core.
interface pc_unit_if;
    import pc_pkg::*;

    logic [XLEN-1:0] pc_plus4_i;
    logic            branch_taken_i;
    logic [XLEN-1:0] branch_target_i;
    logic            jump_i;
    logic [XLEN-1:0] jump_target_i;
    logic            stall_i;
    logic            halt_i;

    logic [XLEN-1:0] pc_o;
    logic            imem_req_o;
    logic            trap_o;
    logic [XLEN-1:0] trap_pc_o;
    logic            halted_o;
    logic [XLEN-1:0] instret_o;
    logic [1:0]      state_o;

    modport slave (
        input  pc_plus4_i, branch_taken_i, branch_target_i, jump_i,
               jump_target_i, stall_i, halt_i,
        output pc_o, imem_req_o, trap_o, trap_pc_o, halted_o, instret_o,
               state_o
    );

    modport master (
        output pc_plus4_i, branch_taken_i, branch_target_i, jump_i,
               jump_target_i, stall_i, halt_i,
        input  pc_o, imem_req_o, trap_o, trap_pc_o, halted_o, instret_o,
               state_o
    );

endinterface

// File: rtl/pc_unit_next_pc_sel.sv
// next_pc_sel: combinational next-PC priority mux (jump > branch > PC+4).
//   pc_plus4_i      - sequential successor from the external adder
//   branch_taken_i  - conditional branch taken
//   branch_target_i - branch destination
//   jump_i          - JAL/JALR
//   jump_target_i   - jump destination
//   next_pc_o       - selected next PC
//   misaligned_o    - selected redirect target is not 4-byte aligned
// Stall and halt are handled by the FSM in the top, not here.
module next_pc_sel
    import pc_pkg::*;
(
    input  logic [XLEN-1:0] pc_plus4_i,
    input  logic            branch_taken_i,
    input  logic [XLEN-1:0] branch_target_i,
    input  logic            jump_i,
    input  logic [XLEN-1:0] jump_target_i,
    output logic [XLEN-1:0] next_pc_o,
    output logic            misaligned_o
);

    // Only redirect targets are alignment-checked; the sequential path is
    // aligned by construction and is allowed to wrap past the top of memory.
    logic redirect;

    always_comb begin
        next_pc_o = pc_plus4_i;
        redirect  = 1'b0;
        if (jump_i) begin
            next_pc_o = jump_target_i;
            redirect  = 1'b1;
        end else if (branch_taken_i) begin
            next_pc_o = branch_target_i;
            redirect  = 1'b1;
        end
    end

    assign misaligned_o = redirect && ((next_pc_o[1:0] & PC_ALIGN_MASK) != 2'b00);

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program-counter stage of the single-cycle core.
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - pc_unit_if.slave: next-PC sources, stall/halt controls, and the
//           PC, fetch-valid, trap/halt flags, retired count and FSM state.
// FSM: BOOT (one idle cycle after reset) -> RUN -> TRAP or HALT, both terminal
// until reset. All outputs come straight from registers or from the state.
module pc_unit
    import pc_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
    input  logic     clk,
    input  logic     rst_n,
    pc_unit_if.slave bus
);

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instret_q, instret_d;
    logic            trap_q, trap_d;
    logic [XLEN-1:0] trap_pc_q, trap_pc_d;
    logic            halted_q, halted_d;

    logic [XLEN-1:0] sel_pc;
    logic            sel_misaligned;

    next_pc_sel u_next_pc_sel (
        .pc_plus4_i      (bus.pc_plus4_i),
        .branch_taken_i  (bus.branch_taken_i),
        .branch_target_i (bus.branch_target_i),
        .jump_i          (bus.jump_i),
        .jump_target_i   (bus.jump_target_i),
        .next_pc_o       (sel_pc),
        .misaligned_o    (sel_misaligned)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instret_d = instret_q;
        trap_d    = trap_q;
        trap_pc_d = trap_pc_q;
        halted_d  = halted_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                // Stall outranks everything, including halt and redirects.
                if (!bus.stall_i) begin
                    if (bus.halt_i) begin
                        state_d  = ST_HALT;
                        halted_d = 1'b1;
                    end else if (sel_misaligned) begin
                        state_d   = ST_TRAP;
                        trap_d    = 1'b1;
                        trap_pc_d = sel_pc;
                    end else begin
                        pc_d      = sel_pc;
                        instret_d = instret_q + 32'd1;
                    end
                end
            end
            default: ; // TRAP / HALT hold everything until reset
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_BOOT;
            pc_q      <= RESET_VECTOR;
            instret_q <= '0;
            trap_q    <= 1'b0;
            trap_pc_q <= '0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instret_q <= instret_d;
            trap_q    <= trap_d;
            trap_pc_q <= trap_pc_d;
            halted_q  <= halted_d;
        end
    end

    assign bus.pc_o       = pc_q;
    assign bus.imem_req_o = (state_q == ST_RUN);
    assign bus.trap_o     = trap_q;
    assign bus.trap_pc_o  = trap_pc_q;
    assign bus.halted_o   = halted_q;
    assign bus.instret_o  = instret_q;
    assign bus.state_o    = state_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a default-vector instance for the main scenarios
// and a second instance preloaded near the top of memory for the wrap case.
module tb_pc_unit;
    import pc_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    pc_unit_if bus ();
    pc_unit_if bus_w ();

    pc_unit u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    pc_unit #(.RESET_VECTOR(32'hFFFF_FFFC)) u_dut_w (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_w)
    );

    // External PC+4 adder model
    assign bus.pc_plus4_i   = bus.pc_o + 32'd4;
    assign bus_w.pc_plus4_i = bus_w.pc_o + 32'd4;

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.branch_taken_i  = 1'b0;
        bus.branch_target_i = '0;
        bus.jump_i          = 1'b0;
        bus.jump_target_i   = '0;
        bus.stall_i         = 1'b0;
        bus.halt_i          = 1'b0;
    endtask

    // Called at posedge+1: pulse reset, release well before the next edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        #3; // no clock edge yet: values must come from the async reset
        checks++; if (bus.pc_o !== 32'h0) begin failures++; $display("FAIL rst_pc got=%h exp=%h", bus.pc_o, 32'h0); end
        checks++; if (bus.imem_req_o !== 1'b0) begin failures++; $display("FAIL rst_imem got=%b exp=0", bus.imem_req_o); end
        checks++; if (bus.trap_o !== 1'b0) begin failures++; $display("FAIL rst_trap got=%b exp=0", bus.trap_o); end
        checks++; if (bus.trap_pc_o !== 32'h0) begin failures++; $display("FAIL rst_trap_pc got=%h exp=0", bus.trap_pc_o); end
        checks++; if (bus.halted_o !== 1'b0) begin failures++; $display("FAIL rst_halted got=%b exp=0", bus.halted_o); end
        checks++; if (bus.instret_o !== 32'h0) begin failures++; $display("FAIL rst_instret got=%h exp=0", bus.instret_o); end
        checks++; if (bus.state_o !== ST_BOOT) begin failures++; $display("FAIL rst_state got=%0d exp=%0d", bus.state_o, ST_BOOT); end
    endtask

    task automatic test_free_run();
        step();
        rst_n = 1'b1;
        // first edge after release: BOOT -> RUN, PC unchanged
        step();
        checks++; if (bus.imem_req_o !== 1'b1) begin failures++; $display("FAIL boot_imem got=%b exp=1", bus.imem_req_o); end
        checks++; if (bus.pc_o !== 32'h0) begin failures++; $display("FAIL boot_pc got=%h exp=0", bus.pc_o); end
        checks++; if (bus.instret_o !== 32'h0) begin failures++; $display("FAIL boot_instret got=%h exp=0", bus.instret_o); end
        for (int i = 1; i <= 4; i++) begin
            step();
            checks++; if (bus.pc_o !== 32'(i * 4)) begin failures++; $display("FAIL run_pc%0d got=%h exp=%h", i, bus.pc_o, 32'(i * 4)); end
        end
        checks++; if (bus.instret_o !== 32'd4) begin failures++; $display("FAIL run_instret got=%0d exp=4", bus.instret_o); end
    endtask

    task automatic test_branch_jump();
        do_reset();
        step();        // BOOT -> RUN at pc 0
        step();        // pc 4
        step();        // pc 8
        checks++; if (bus.pc_o !== 32'h8) begin failures++; $display("FAIL br_pre_pc got=%h exp=8", bus.pc_o); end
        bus.branch_taken_i  = 1'b1;
        bus.branch_target_i = 32'h0000_0100;
        step();
        checks++; if (bus.pc_o !== 32'h100) begin failures++; $display("FAIL br_pc got=%h exp=100", bus.pc_o); end
        checks++; if (bus.instret_o !== 32'd3) begin failures++; $display("FAIL br_instret got=%0d exp=3", bus.instret_o); end
        bus.jump_i        = 1'b1;
        bus.jump_target_i = 32'h0000_0200;
        step();
        checks++; if (bus.pc_o !== 32'h200) begin failures++; $display("FAIL jb_pc got=%h exp=200", bus.pc_o); end
        checks++; if (bus.instret_o !== 32'd4) begin failures++; $display("FAIL jb_instret got=%0d exp=4", bus.instret_o); end
        clear_inputs();
    endtask

    task automatic test_stall();
        bus.stall_i       = 1'b1;
        bus.jump_i        = 1'b1;
        bus.jump_target_i = 32'h0000_0300;
        bus.halt_i        = 1'b1; // must be ignored under stall
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (bus.pc_o !== 32'h200) begin failures++; $display("FAIL stall_pc%0d got=%h exp=200", i, bus.pc_o); end
            checks++; if (bus.instret_o !== 32'd4) begin failures++; $display("FAIL stall_instret%0d got=%0d exp=4", i, bus.instret_o); end
        end
        checks++; if (bus.halted_o !== 1'b0) begin failures++; $display("FAIL stall_halted got=%b exp=0", bus.halted_o); end
        bus.stall_i = 1'b0;
        bus.halt_i  = 1'b0;
        step();
        checks++; if (bus.pc_o !== 32'h300) begin failures++; $display("FAIL unstall_pc got=%h exp=300", bus.pc_o); end
        checks++; if (bus.instret_o !== 32'd5) begin failures++; $display("FAIL unstall_instret got=%0d exp=5", bus.instret_o); end
        clear_inputs();
    endtask

    task automatic test_trap();
        bus.jump_i          = 1'b1;
        bus.jump_target_i   = 32'h0000_0102;
        bus.branch_taken_i  = 1'b1;
        bus.branch_target_i = 32'h0000_0400; // aligned, but jump wins
        step();
        checks++; if (bus.trap_o !== 1'b1) begin failures++; $display("FAIL trap_flag got=%b exp=1", bus.trap_o); end
        checks++; if (bus.trap_pc_o !== 32'h102) begin failures++; $display("FAIL trap_pc got=%h exp=102", bus.trap_pc_o); end
        checks++; if (bus.pc_o !== 32'h300) begin failures++; $display("FAIL trap_hold_pc got=%h exp=300", bus.pc_o); end
        checks++; if (bus.imem_req_o !== 1'b0) begin failures++; $display("FAIL trap_imem got=%b exp=0", bus.imem_req_o); end
        checks++; if (bus.instret_o !== 32'd5) begin failures++; $display("FAIL trap_instret got=%0d exp=5", bus.instret_o); end
        checks++; if (bus.state_o !== ST_TRAP) begin failures++; $display("FAIL trap_state got=%0d exp=%0d", bus.state_o, ST_TRAP); end
        bus.jump_target_i = 32'h0000_0500;
        bus.halt_i        = 1'b1;
        step();
        step();
        checks++; if (bus.pc_o !== 32'h300) begin failures++; $display("FAIL trap_term_pc got=%h exp=300", bus.pc_o); end
        checks++; if (bus.trap_pc_o !== 32'h102) begin failures++; $display("FAIL trap_term_tpc got=%h exp=102", bus.trap_pc_o); end
        checks++; if (bus.halted_o !== 1'b0) begin failures++; $display("FAIL trap_term_halted got=%b exp=0", bus.halted_o); end
        clear_inputs();
    endtask

    task automatic test_halt_async_reset();
        do_reset();
        step();                        // RUN, pc 0
        for (int i = 0; i < 4; i++) step(); // pc 0x10
        checks++; if (bus.pc_o !== 32'h10) begin failures++; $display("FAIL halt_pre_pc got=%h exp=10", bus.pc_o); end
        bus.halt_i = 1'b1;
        step();
        checks++; if (bus.halted_o !== 1'b1) begin failures++; $display("FAIL halt_flag got=%b exp=1", bus.halted_o); end
        checks++; if (bus.pc_o !== 32'h10) begin failures++; $display("FAIL halt_pc got=%h exp=10", bus.pc_o); end
        checks++; if (bus.imem_req_o !== 1'b0) begin failures++; $display("FAIL halt_imem got=%b exp=0", bus.imem_req_o); end
        checks++; if (bus.instret_o !== 32'd4) begin failures++; $display("FAIL halt_instret got=%0d exp=4", bus.instret_o); end
        bus.halt_i = 1'b0;
        step();
        checks++; if (bus.halted_o !== 1'b1) begin failures++; $display("FAIL halt_sticky got=%b exp=1", bus.halted_o); end
        #2;
        rst_n = 1'b0;  // mid-cycle, away from any edge
        #1;
        checks++; if (bus.halted_o !== 1'b0) begin failures++; $display("FAIL arst_halted got=%b exp=0", bus.halted_o); end
        checks++; if (bus.pc_o !== 32'h0) begin failures++; $display("FAIL arst_pc got=%h exp=0", bus.pc_o); end
        checks++; if (bus.instret_o !== 32'h0) begin failures++; $display("FAIL arst_instret got=%h exp=0", bus.instret_o); end
        checks++; if (bus.state_o !== ST_BOOT) begin failures++; $display("FAIL arst_state got=%0d exp=%0d", bus.state_o, ST_BOOT); end
        checks++; if (bus.imem_req_o !== 1'b0) begin failures++; $display("FAIL arst_imem got=%b exp=0", bus.imem_req_o); end
        clear_inputs();
    endtask

    task automatic test_wrap();
        // rst_n is still low here from the async-reset scenario
        checks++; if (bus_w.pc_o !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_rst_pc got=%h exp=fffffffc", bus_w.pc_o); end
        step();
        rst_n = 1'b1;
        step();
        checks++; if (bus_w.pc_o !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_boot_pc got=%h exp=fffffffc", bus_w.pc_o); end
        checks++; if (bus_w.imem_req_o !== 1'b1) begin failures++; $display("FAIL wrap_imem got=%b exp=1", bus_w.imem_req_o); end
        step();
        checks++; if (bus_w.pc_o !== 32'h0) begin failures++; $display("FAIL wrap_pc got=%h exp=0", bus_w.pc_o); end
        checks++; if (bus_w.trap_o !== 1'b0) begin failures++; $display("FAIL wrap_trap got=%b exp=0", bus_w.trap_o); end
        checks++; if (bus_w.instret_o !== 32'd1) begin failures++; $display("FAIL wrap_instret got=%0d exp=1", bus_w.instret_o); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        checks   = 0;
        failures = 0;
        clear_inputs();
        bus_w.branch_taken_i  = 1'b0;
        bus_w.branch_target_i = '0;
        bus_w.jump_i          = 1'b0;
        bus_w.jump_target_i   = '0;
        bus_w.stall_i         = 1'b0;
        bus_w.halt_i          = 1'b0;

        test_reset();
        test_free_run();
        test_branch_jump();
        test_stall();
        test_trap();
        test_halt_async_reset();
        test_wrap();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Program-counter stage that sits directly upstream of the PC+4 adder in the single-cycle RISC-V core. It holds the architectural PC in a register and drives it to the adder and instruction memory. Each cycle it picks the next PC from the adder's PC+4 result, a branch target, or a jump target. It also handles stall, halt, misaligned-target trap and a retired-instruction counter.

## Interface
Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- pc_plus4_i  input  32  PC+4 returned by the adder stage.
- branch_taken_i  input  1  conditional branch resolved taken this cycle.
- branch_target_i  input  32  branch destination.
- jump_i  input  1  JAL/JALR this cycle.
- jump_target_i  input  32  jump destination.
- stall_i  input  1  freeze PC and counter this cycle.
- halt_i  input  1  current instruction is a halt (ECALL/EBREAK).
- pc_o  output  32  current PC, to the adder and instruction memory.
- imem_req_o  output  1  instruction fetch valid.
- trap_o  output  1  sticky misaligned-target trap flag.
- trap_pc_o  output  32  offending target address that was captured.
- halted_o  output  1  sticky halted flag.
- instret_o  output  32  count of retired instructions.

## Operation
- FSM states: BOOT, RUN, TRAP, HALT.
- BOOT goes to RUN unconditionally on the next edge. PC is unchanged in BOOT and imem_req_o=0.
- RUN: imem_req_o=1.
- Next-PC priority in RUN: stall_i, then halt_i, then jump_i, then branch_taken_i, then pc_plus4_i.
- stall_i=1: PC, instret_o and state hold. halt_i, jump_i and branch inputs are ignored that cycle.
- halt_i=1 (no stall): go to HALT and set halted_o=1. PC holds and instret_o does not increment.
- Selected target with bits[1:0] != 0 (jump or branch): go to TRAP, set trap_o=1 and capture the target in trap_pc_o. PC holds and instret_o does not increment.
- Normal advance: PC <= selected value and instret_o <= instret_o + 1.
- instret_o wraps modulo 2^32.
- The pc_plus4_i path is never alignment-checked and wraps naturally (32'hFFFF_FFFC -> 0).
- TRAP and HALT are terminal: imem_req_o=0, all registers hold, inputs are ignored. The only exit is reset.
- jump_i and branch_taken_i asserted together: jump wins and only jump_target_i is checked.

## Timing
- Reset values: pc_o=RESET_VECTOR, imem_req_o=0, trap_o=0, trap_pc_o=0, halted_o=0, instret_o=0, state=BOOT.
- Reset is asynchronous. If asserted mid-operation, it forces the above values immediately, regardless of state or clk.
- All outputs are registered, or decoded from registered state only. No combinational input-to-output path.
- Next-PC decode is combinational from the current-cycle inputs. The update takes effect on the following rising edge, so PC-to-PC latency is 1 cycle.
- The first fetch (imem_req_o=1 with pc_o=RESET_VECTOR) occurs in the 2nd cycle after rst_n deasserts.
- TRAP/HALT flags become visible the cycle after the triggering edge and stay set until reset.

## Structure
- Shared package pc_pkg holds:
  - pc_state_t enum (BOOT, RUN, TRAP, HALT);
  - XLEN=32;
  - PC_ALIGN_MASK=2'b11;
  - the default RESET_VECTOR.
- One natural sub-module, next_pc_sel. It is purely combinational: it takes the priority mux inputs and produces next_pc and misaligned.
- pc_unit holds the FSM, the PC register, the trap/halt flags and instret.
- The PC+4 adder stays external. pc_o feeds it and pc_plus4_i returns from it.

## Test plan
- Reset then free-run: BOOT for 1 cycle, then pc_o steps 0, 4, 8, 12. After 4 advance edges instret_o=4.
- Branch to 32'h0000_0100 with branch_taken_i=1 at pc 8: next pc_o=0x100, instret increments. Jump and branch asserted together: jump_target_i=0x200 wins over branch 0x100.
- stall_i held 3 cycles with jump_i=1: pc_o and instret_o unchanged. Jump taken on the first cycle after stall_i drops.
- Jump to 32'h0000_0102: trap_o=1 and trap_pc_o=0x102 next cycle, pc_o holds, imem_req_o=0. Later inputs are ignored.
- halt_i at pc 0x10: halted_o=1, pc_o stays 0x10, imem_req_o=0. Then assert rst_n=0 asynchronously mid-cycle: all outputs return to reset values immediately.
- Preload pc_o=32'hFFFF_FFFC via RESET_VECTOR, advance with pc_plus4_i=0: pc_o wraps to 0 with no trap.
